// File: rtl/cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : cmd_parser
// Brief    : Host command decoder. Pops bytes from a first-word-fall-through
//            RX FIFO, collects per-command payload, writes an 8-bit settings
//            register file, fires busy-gated trigger pulses and returns
//            register readback words over a req/accept port. A payload /
//            busy timeout and a saturating error counter allow recovery
//            from a stalled or malformed host stream.
//            Optional feature macro: CMD_PARSER_READBACK_EN (enables 0x41
//            read command, RESP state and the tx port).
//            state_dbg encoding: 0 IDLE, 1 DECODE, 2 PAYLOAD, 3 EXEC,
//            4 RESP, 5 WAIT_TRIG.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_parser #(
    parameter int NUM_REGS = 4,
    parameter int NUM_TRIG = 4,
    parameter int TIMEOUT  = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_rdata,
    input  logic                  rx_rempty,
    output logic                  rx_rinc,
    output logic [NUM_TRIG-1:0]   trig_out,
    input  logic [NUM_TRIG-1:0]   trig_busy,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic                  tx_req,
    output logic [15:0]           tx_data,
    input  logic                  tx_accept,
    output logic [7:0]            err_cnt,
    output logic [3:0]            state_dbg
);

    localparam int                    c_tcnt_w   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_tcnt_w-1:0]   c_tcnt_max = c_tcnt_w'(TIMEOUT - 1);
    localparam logic [7:0]            c_cmd_rst  = 8'h00;
    localparam logic [7:0]            c_cmd_wr   = 8'h40;
    localparam logic [7:0]            c_cmd_rd   = 8'h41;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_DECODE    = 4'd1,
        S_PAYLOAD   = 4'd2,
        S_EXEC      = 4'd3,
        S_RESP      = 4'd4,
        S_WAIT_TRIG = 4'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_run;        // low while in reset so no pop happens then
    logic [7:0]              r_cmd;
    logic [7:0]              r_addr;
    logic [7:0]              r_data;
    logic                    r_have_addr;
    logic [1:0]              r_left;       // payload bytes still to collect
    logic [c_tcnt_w-1:0]     r_tcnt;
    logic [7:0]              r_err;
    logic [NUM_TRIG-1:0]     r_trig;
    logic [8*NUM_REGS-1:0]   r_regs;

    logic                    w_rinc;
    logic                    w_err_inc;
    logic                    w_clr_all;
    logic                    w_wr;
    logic                    w_fire;
    logic                    w_stall;
    logic                    w_load_tx;
    logic [5:0]              w_trig_idx;
    logic [NUM_TRIG-1:0]     w_trig_sel;
    logic                    w_is_trig;
    logic                    w_busy;
    logic                    w_addr_ok;

    assign w_trig_idx = r_cmd[5:0] - 6'd1;
    assign w_trig_sel = NUM_TRIG'(1) << w_trig_idx;
    assign w_is_trig  = (r_cmd != 8'h00) && (r_cmd <= 8'(NUM_TRIG));
    assign w_busy     = |(trig_busy & w_trig_sel);
    assign w_addr_ok  = ({1'b0, r_addr} < 9'(NUM_REGS));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle action decode
    always_comb begin
        w_state_nxt = r_state;
        w_rinc      = 1'b0;
        w_err_inc   = 1'b0;
        w_clr_all   = 1'b0;
        w_wr        = 1'b0;
        w_fire      = 1'b0;
        w_stall     = 1'b0;
        w_load_tx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Hold off the pop while a trigger pulse is on the wire
                if (r_run && !rx_rempty && (r_trig == '0)) begin
                    w_rinc      = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (r_cmd == c_cmd_rst) begin
                    w_clr_all   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_is_trig) begin
                    w_state_nxt = S_WAIT_TRIG;
                end else if (r_cmd == c_cmd_wr) begin
                    w_state_nxt = S_PAYLOAD;
`ifdef CMD_PARSER_READBACK_EN
                end else if (r_cmd == c_cmd_rd) begin
                    w_state_nxt = S_PAYLOAD;
`endif
                end else begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (!rx_rempty) begin
                    w_rinc = 1'b1;
                    if (r_left == 2'd1) begin
                        w_state_nxt = S_EXEC;
                    end
                end else begin
                    w_stall = 1'b1;
                    if (r_tcnt == c_tcnt_max) begin
                        w_err_inc   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_EXEC: begin
                w_state_nxt = S_IDLE;
                if (!w_addr_ok) begin
                    w_err_inc = 1'b1;
                end else if (r_cmd == c_cmd_wr) begin
                    w_wr = 1'b1;
                end else begin
`ifdef CMD_PARSER_READBACK_EN
                    w_load_tx   = 1'b1;
                    w_state_nxt = S_RESP;
`endif
                end
            end
            S_RESP: begin
`ifdef CMD_PARSER_READBACK_EN
                if (tx_accept) begin
                    w_state_nxt = S_IDLE;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_WAIT_TRIG: begin
                if (!w_busy) begin
                    w_fire      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_tcnt == c_tcnt_max) begin
                        w_err_inc   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command/payload capture, timeout counter, error counter and trigger pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_cmd       <= 8'h00;
            r_addr      <= 8'h00;
            r_data      <= 8'h00;
            r_have_addr <= 1'b0;
            r_left      <= 2'd0;
            r_tcnt      <= '0;
            r_err       <= 8'h00;
            r_trig      <= '0;
        end else begin
            r_run  <= 1'b1;
            r_trig <= w_fire ? w_trig_sel : '0;

            if ((r_state == S_IDLE) && w_rinc) begin
                r_cmd <= rx_rdata;
            end

            if (r_state == S_DECODE) begin
                r_left      <= (r_cmd == c_cmd_wr) ? 2'd2 : 2'd1;
                r_have_addr <= 1'b0;
            end else if ((r_state == S_PAYLOAD) && w_rinc) begin
                r_left <= r_left - 2'd1;
                if (!r_have_addr) begin
                    r_addr      <= rx_rdata;
                    r_have_addr <= 1'b1;
                end else begin
                    r_data <= rx_rdata;
                end
            end

            // Timer restarts on every state change and only counts stall cycles
            if (w_state_nxt != r_state) begin
                r_tcnt <= '0;
            end else if (w_stall) begin
                r_tcnt <= r_tcnt + c_tcnt_w'(1);
            end

            if (w_clr_all) begin
                r_err <= 8'h00;
            end else if (w_err_inc && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end

    // Settings register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
        end else if (w_clr_all) begin
            r_regs <= '0;
        end else if (w_wr) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (r_addr == 8'(k)) begin
                    r_regs[8*k +: 8] <= r_data;
                end
            end
        end
    end

`ifdef CMD_PARSER_READBACK_EN
    logic [7:0]  w_rd_data;
    logic [15:0] r_tx_data;

    // Readback mux over the register file
    always_comb begin
        w_rd_data = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (r_addr == 8'(k)) begin
                w_rd_data = r_regs[8*k +: 8];
            end
        end
    end

    // Readback word is loaded in EXEC and held stable through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data <= 16'h0000;
        end else if (w_load_tx) begin
            r_tx_data <= {r_addr, w_rd_data};
        end
    end

    assign tx_req  = (r_state == S_RESP);
    assign tx_data = r_tx_data;
`else
    logic w_unused_tx;
    assign w_unused_tx = tx_accept | w_load_tx;
    assign tx_req      = 1'b0;
    assign tx_data     = 16'h0000;
`endif

    assign rx_rinc   = w_rinc;
    assign trig_out  = r_trig;
    assign reg_out   = r_regs;
    assign err_cnt   = r_err;
    assign state_dbg = r_state;

endmodule
`default_nettype wire
